zap_regfile_write_arbiter: RTL and testbench

//  Shares the register file's two write ports between the writeback pipeline and the coprocessor.
//  - Pipeline writes (port A, port B) always win and are never back-pressured.
//  - Coprocessor writes are buffered in an in-order FIFO and drained into idle port slots.
//  - A hazard query reports buffered writes so issue can stall dependent reads.
//  - A starvation counter forces a pipeline bubble when the FIFO cannot drain.

---
 rtl/zap_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_zap_regfile_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_regfile_write_arbiter.sv
// zap_regfile_write_arbiter
// Shares the two register-file write ports between the writeback pipeline
// and the coprocessor. Pipeline writes always take their slot; coprocessor
// writes are queued in an in-order FIFO and drained into slots the pipeline
// leaves idle. A hazard query exposes buffered indices to issue, and a
// starvation counter asks for a pipeline bubble when the FIFO cannot drain.
module zap_regfile_write_arbiter #(
    parameter int PHY_REGS     = 46,
    parameter int RAZ_INDEX    = PHY_REGS - 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int W           = $clog2(PHY_REGS),
    localparam int PW          = $clog2(FIFO_DEPTH),
    localparam int LW          = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_pipe_wen,
    input  logic [W-1:0]  i_pipe_wa_a,
    input  logic [31:0]   i_pipe_wd_a,
    input  logic [W-1:0]  i_pipe_wa_b,
    input  logic [31:0]   i_pipe_wd_b,
    input  logic          i_cp_valid,
    input  logic [W-1:0]  i_cp_wa,
    input  logic [31:0]   i_cp_wd,
    output logic          o_cp_ready,
    input  logic [W-1:0]  i_hz_index,
    output logic          o_hz_hit,
    output logic          o_stall_pipe,
    output logic          o_wen,
    output logic [W-1:0]  o_wa_a,
    output logic [31:0]   o_wd_a,
    output logic [W-1:0]  o_wa_b,
    output logic [31:0]   o_wd_b,
    output logic [LW-1:0] o_fifo_level
);

    localparam logic [W-1:0]  RAZ   = W'(RAZ_INDEX);
    localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);
    localparam logic [7:0]    LIMIT = 8'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [W-1:0]  mem_wa_q [FIFO_DEPTH];
    logic [31:0]   mem_wd_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    starve_q, starve_d;
    logic          stall_q, stall_d;

    // Registered write ports
    logic          wen_q, wen_d;
    logic [W-1:0]  wa_a_q, wa_a_d, wa_b_q, wa_b_d;
    logic [31:0]   wd_a_q, wd_a_d, wd_b_q, wd_b_d;

    // Per-cycle decode
    logic          busy_a_s, busy_b_s;
    logic          head_valid_s, collide_s;
    logic          to_a_s, to_b_s, pop_s, push_s, cp_ready_s, hz_hit_s;
    logic [W-1:0]  head_wa_s;
    logic [31:0]   head_wd_s;

    // Slot occupancy, drain/collision decision and FIFO handshake.
    always_comb begin
        busy_a_s     = i_pipe_wen && (i_pipe_wa_a != RAZ);
        busy_b_s     = i_pipe_wen && (i_pipe_wa_b != RAZ);
        head_valid_s = (level_q != {LW{1'b0}});
        head_wa_s    = mem_wa_q[rd_ptr_q];
        head_wd_s    = mem_wd_q[rd_ptr_q];
        // An older buffered write to a register the pipeline writes now is dead.
        collide_s    = head_valid_s &&
                       ((busy_a_s && (head_wa_s == i_pipe_wa_a)) ||
                        (busy_b_s && (head_wa_s == i_pipe_wa_b)));
        // Prefer the memory-side slot B, fall back to A.
        to_b_s       = head_valid_s && !collide_s && !busy_b_s;
        to_a_s       = head_valid_s && !collide_s && busy_b_s && !busy_a_s;
        pop_s        = collide_s || to_b_s || to_a_s;
        cp_ready_s   = (level_q != FULL);
        push_s       = i_cp_valid && cp_ready_s;
    end

    // Next state for pointers, occupancy, starvation counter and write ports.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (!head_valid_s || pop_s) begin
            starve_d = 8'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
        stall_d = (starve_d == LIMIT);

        if (busy_a_s) begin
            wa_a_d = i_pipe_wa_a;
            wd_a_d = i_pipe_wd_a;
        end else if (to_a_s) begin
            wa_a_d = head_wa_s;
            wd_a_d = head_wd_s;
        end else begin
            wa_a_d = RAZ;
            wd_a_d = 32'd0;
        end

        if (busy_b_s) begin
            wa_b_d = i_pipe_wa_b;
            wd_b_d = i_pipe_wd_b;
        end else if (to_b_s) begin
            wa_b_d = head_wa_s;
            wd_b_d = head_wd_s;
        end else begin
            wa_b_d = RAZ;
            wd_b_d = 32'd0;
        end

        wen_d = (wa_a_d != RAZ) || (wa_b_d != RAZ);
    end

    // Hazard lookup across the live window [rd_ptr, rd_ptr + level).
    always_comb begin
        hz_hit_s = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - rd_ptr_q)} < level_q) &&
                (mem_wa_q[i] == i_hz_index)) begin
                hz_hit_s = 1'b1;
            end else begin
                hz_hit_s = hz_hit_s;
            end
        end
        if (i_hz_index == RAZ) begin
            hz_hit_s = 1'b0;
        end else begin
            hz_hit_s = hz_hit_s;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers and level.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_wa_q[wr_ptr_q] <= i_cp_wa;
            mem_wd_q[wr_ptr_q] <= i_cp_wd;
        end
    end

    // Control state and registered write ports with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            starve_q <= 8'd0;
            stall_q  <= 1'b0;
            wen_q    <= 1'b0;
            wa_a_q   <= RAZ;
            wd_a_q   <= 32'd0;
            wa_b_q   <= RAZ;
            wd_b_q   <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wen_q    <= wen_d;
            wa_a_q   <= wa_a_d;
            wd_a_q   <= wd_a_d;
            wa_b_q   <= wa_b_d;
            wd_b_q   <= wd_b_d;
        end
    end

    assign o_cp_ready   = cp_ready_s;
    assign o_hz_hit     = hz_hit_s;
    assign o_stall_pipe = stall_q;
    assign o_wen        = wen_q;
    assign o_wa_a       = wa_a_q;
    assign o_wd_a       = wd_a_q;
    assign o_wa_b       = wa_b_q;
    assign o_wd_b       = wd_b_q;
    assign o_fifo_level = level_q;

endmodule

// File: tb/tb_zap_regfile_write_arbiter.sv
// Directed bench for zap_regfile_write_arbiter. Stimulus pushes the
// hand-computed expected write-port contents into a queue; a forked monitor
// pops and compares whenever the DUT asserts o_wen.
module tb_zap_regfile_write_arbiter;

    localparam logic [5:0] R = 6'd45;

    logic        clk = 1'b0;
    logic        i_reset, i_pipe_wen, i_cp_valid;
    logic [5:0]  i_pipe_wa_a, i_pipe_wa_b, i_cp_wa, i_hz_index;
    logic [31:0] i_pipe_wd_a, i_pipe_wd_b, i_cp_wd;
    logic        o_cp_ready, o_hz_hit, o_stall_pipe, o_wen;
    logic [5:0]  o_wa_a, o_wa_b;
    logic [31:0] o_wd_a, o_wd_b;
    logic [2:0]  o_fifo_level;

    typedef struct packed {
        logic [5:0]  wa_a;
        logic [31:0] wd_a;
        logic [5:0]  wa_b;
        logic [31:0] wd_b;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    zap_regfile_write_arbiter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_pipe_wen   (i_pipe_wen),
        .i_pipe_wa_a  (i_pipe_wa_a),
        .i_pipe_wd_a  (i_pipe_wd_a),
        .i_pipe_wa_b  (i_pipe_wa_b),
        .i_pipe_wd_b  (i_pipe_wd_b),
        .i_cp_valid   (i_cp_valid),
        .i_cp_wa      (i_cp_wa),
        .i_cp_wd      (i_cp_wd),
        .o_cp_ready   (o_cp_ready),
        .i_hz_index   (i_hz_index),
        .o_hz_hit     (o_hz_hit),
        .o_stall_pipe (o_stall_pipe),
        .o_wen        (o_wen),
        .o_wa_a       (o_wa_a),
        .o_wd_a       (o_wd_a),
        .o_wa_b       (o_wa_b),
        .o_wd_b       (o_wd_b),
        .o_fifo_level (o_fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expw(input logic [5:0] a, input logic [31:0] da,
                        input logic [5:0] b, input logic [31:0] db);
        wr_t e;
        e.wa_a = a; e.wd_a = da; e.wa_b = b; e.wd_b = db;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic pw, input logic [5:0] a, input logic [31:0] da,
                         input logic [5:0] b, input logic [31:0] db,
                         input logic cv, input logic [5:0] ci, input logic [31:0] cd);
        i_pipe_wen  = pw;
        i_pipe_wa_a = a;  i_pipe_wd_a = da;
        i_pipe_wa_b = b;  i_pipe_wd_b = db;
        i_cp_valid  = cv; i_cp_wa = ci; i_cp_wd = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, R, 32'd0, R, 32'd0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic monitor_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (o_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got a=%0d/0x%0h b=%0d/0x%0h expected no write",
                             o_wa_a, o_wd_a, o_wa_b, o_wd_b);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_wa_a", 32'(o_wa_a), 32'(e.wa_a));
                    chk("sb_wd_a", o_wd_a, e.wd_a);
                    chk("sb_wa_b", 32'(o_wa_b), 32'(e.wa_b));
                    chk("sb_wd_b", o_wd_b, e.wd_b);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b1;
        i_hz_index = R;
        i_pipe_wen = 1'b0; i_pipe_wa_a = R; i_pipe_wd_a = 32'd0;
        i_pipe_wa_b = R; i_pipe_wd_b = 32'd0;
        i_cp_valid = 1'b0; i_cp_wa = 6'd0; i_cp_wd = 32'd0;
        fork
            monitor_loop();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   32'(o_wen), 32'd0);
        chk("rst_wa_a",  32'(o_wa_a), 32'(R));
        chk("rst_wa_b",  32'(o_wa_b), 32'(R));
        chk("rst_wd_a",  o_wd_a, 32'd0);
        chk("rst_wd_b",  o_wd_b, 32'd0);
        chk("rst_stall", 32'(o_stall_pipe), 32'd0);
        chk("rst_ready", 32'(o_cp_ready), 32'd1);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        i_reset = 1'b0;

        // 1: pipeline port A only, B at the read-as-zero index
        expw(6'd3, 32'h11, R, 32'd0);
        drive(1'b1, 6'd3, 32'h11, R, 32'hDEAD, 1'b0, 6'd0, 32'd0);
        chk("t1_wen", 32'(o_wen), 32'd1);
        idle();
        chk("t1_idle_wen", 32'(o_wen), 32'd0);

        // 2: single coprocessor write, two-cycle latency into slot B
        drive(1'b0, R, 32'd0, R, 32'd0, 1'b1, 6'd5, 32'hAA);
        chk("t2_level1", 32'(o_fifo_level), 32'd1);
        chk("t2_no_early_wen", 32'(o_wen), 32'd0);
        expw(R, 32'd0, 6'd5, 32'hAA);
        idle();
        chk("t2_level0", 32'(o_fifo_level), 32'd0);
        chk("t2_wen", 32'(o_wen), 32'd1);

        // 3: pipeline owns both slots for 20 cycles, FIFO fills and starves
        for (int k = 0; k < 20; k++) begin
            expw(6'd1, 32'h100 + 32'(k), 6'd2, 32'h200 + 32'(k));
            drive(1'b1, 6'd1, 32'h100 + 32'(k), 6'd2, 32'h200 + 32'(k),
                  (k < 5), (k < 4) ? 6'(10 + k) : 6'd14, 32'hC0 + 32'(k));
            chk("t3_stall", 32'(o_stall_pipe), (k >= 8) ? 32'd1 : 32'd0);
            chk("t3_level", 32'(o_fifo_level), (k < 3) ? 32'(k + 1) : 32'd4);
            if (k == 3) chk("t3_ready_full", 32'(o_cp_ready), 32'd0);
        end
        for (int j = 0; j < 4; j++) begin
            expw(R, 32'd0, 6'(10 + j), 32'hC0 + 32'(j));
            idle();
            chk("t3_drain_level", 32'(o_fifo_level), 32'(3 - j));
            chk("t3_drain_stall", 32'(o_stall_pipe), 32'd0);
            chk("t3_drain_ready", 32'(o_cp_ready), 32'd1);
        end
        idle();

        // 4: collision discards the head; then drain into slot A when B busy
        expw(6'd20, 32'h5, 6'd21, 32'h6);
        drive(1'b1, 6'd20, 32'h5, 6'd21, 32'h6, 1'b1, 6'd7, 32'h1);
        chk("t4_level1", 32'(o_fifo_level), 32'd1);
        expw(6'd7, 32'h2, 6'd22, 32'h3);
        drive(1'b1, 6'd7, 32'h2, 6'd22, 32'h3, 1'b0, 6'd0, 32'd0);
        chk("t4_discard_level", 32'(o_fifo_level), 32'd0);
        repeat (3) idle();
        expw(6'd1, 32'h10, 6'd2, 32'h20);
        drive(1'b1, 6'd1, 32'h10, 6'd2, 32'h20, 1'b1, 6'd30, 32'h77);
        expw(6'd30, 32'h77, 6'd3, 32'h33);
        drive(1'b1, R, 32'hBAD, 6'd3, 32'h33, 1'b0, 6'd0, 32'd0);
        chk("t4_slot_a_level", 32'(o_fifo_level), 32'd0);

        // 5: hazard query, including a buffered write to the RAZ index
        expw(6'd1, 32'h1, 6'd2, 32'h2);
        drive(1'b1, 6'd1, 32'h1, 6'd2, 32'h2, 1'b1, 6'd9, 32'h99);
        expw(6'd1, 32'h3, 6'd2, 32'h4);
        drive(1'b1, 6'd1, 32'h3, 6'd2, 32'h4, 1'b1, R, 32'h55);
        chk("t5_level2", 32'(o_fifo_level), 32'd2);
        i_hz_index = 6'd9; #1;
        chk("t5_hit9", 32'(o_hz_hit), 32'd1);
        i_hz_index = R; #1;
        chk("t5_hit_raz", 32'(o_hz_hit), 32'd0);
        i_hz_index = 6'd10; #1;
        chk("t5_hit10", 32'(o_hz_hit), 32'd0);
        expw(R, 32'd0, 6'd9, 32'h99);
        idle();
        chk("t5_level1", 32'(o_fifo_level), 32'd1);
        i_hz_index = 6'd9; #1;
        chk("t5_hit9_after", 32'(o_hz_hit), 32'd0);
        idle();
        chk("t5_level0", 32'(o_fifo_level), 32'd0);
        i_hz_index = R;

        // 6: reset with three buffered writes drops them all
        for (int k = 0; k < 3; k++) begin
            expw(6'd1, 32'h60 + 32'(k), 6'd2, 32'h70 + 32'(k));
            drive(1'b1, 6'd1, 32'h60 + 32'(k), 6'd2, 32'h70 + 32'(k),
                  1'b1, 6'(40 + k), 32'hE0 + 32'(k));
        end
        chk("t6_level3", 32'(o_fifo_level), 32'd3);
        i_reset = 1'b1;
        idle();
        i_reset = 1'b0;
        chk("t6_level0", 32'(o_fifo_level), 32'd0);
        chk("t6_wen", 32'(o_wen), 32'd0);
        chk("t6_ready", 32'(o_cp_ready), 32'd1);
        chk("t6_wa_a", 32'(o_wa_a), 32'(R));
        chk("t6_wa_b", 32'(o_wa_b), 32'(R));
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("t6_no_write", 32'(o_wen), 32'd0);
        end

        repeat (2) idle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
